pwm_fade_ctrl: RTL

Duty-cycle sequencer for the `pwm` generator. It ramps a PWM duty cycle from its current value to a requested target in fixed steps, changing the value only at PWM period boundaries so no partial period ever carries a mixed duty. It sits between the LED/button control logic and one `pwm` instance, and drives that instance's `i_duty_cycle`. With the configuration macro compiled in, it can also "breathe" continuously between zero and the target.

---
 rtl/pwm_fade_ctrl_if.sv | 56 +++++
 rtl/pwm_fade_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl_if
// Purpose  : Control/status bundle between the LED/button control logic
//            (master) and the pwm_fade_ctrl duty sequencer (slave).
// Signals  : i_start       - one-cycle pulse, latch target/step, begin ramp
//            i_stop        - one-cycle pulse, abort ramp and freeze duty
//            i_target      - requested final duty (WL bits)
//            i_step        - duty increment per step, 0 behaves as 1 (WL bits)
//            i_breathe     - breathe-mode select, sampled with i_start
//            o_duty_cycle  - duty value for pwm.i_duty_cycle (WL bits)
//            o_busy        - high while a ramp is in progress
//            o_done        - one-cycle pulse when the target is reached
//            o_period_tick - one-cycle pulse on the last cycle of a PWM period
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_fade_ctrl_if #(
  parameter int WL = 4
);
  logic          i_start;
  logic          i_stop;
  logic [WL-1:0] i_target;
  logic [WL-1:0] i_step;
  logic          i_breathe;
  logic [WL-1:0] o_duty_cycle;
  logic          o_busy;
  logic          o_done;
  logic          o_period_tick;

  // Control side: issues commands, observes status.
  modport master (
    output i_start,
    output i_stop,
    output i_target,
    output i_step,
    output i_breathe,
    input  o_duty_cycle,
    input  o_busy,
    input  o_done,
    input  o_period_tick
  );

  // Sequencer side: accepts commands, produces status.
  modport slave (
    input  i_start,
    input  i_stop,
    input  i_target,
    input  i_step,
    input  i_breathe,
    output o_duty_cycle,
    output o_busy,
    output o_done,
    output o_period_tick
  );
endinterface
`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Purpose  : Duty-cycle sequencer for a pwm generator. Ramps the duty from its
//            current value to a requested target in fixed steps, updating it
//            only at PWM period boundaries so every period carries exactly one
//            duty value.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            bus  - pwm_fade_ctrl_if.slave (start/stop/target/step/breathe in,
//                   duty/busy/done/period_tick out, all outputs registered)
// Options  : PWM_FADE_BREATHE_EN - when defined, i_breathe=1 at i_start makes
//            the duty bounce between the target and 0 until i_stop.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl #(
  parameter int CLK_FREQ     = 100000000,
  parameter int PWM_FREQ     = 20000,
  parameter int WL           = $clog2(CLK_FREQ / PWM_FREQ),
  parameter int STEP_PERIODS = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pwm_fade_ctrl_if.slave bus
);

  // Period counter runs 0..PERIOD_CNT, i.e. PERIOD_CNT+1 cycles per period,
  // identical to the counter inside the driven pwm.
  localparam int PERIOD_CNT = CLK_FREQ / PWM_FREQ;
  localparam int C_CNT_W    = $clog2(PERIOD_CNT + 1);
  localparam int C_STEP_W   = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [C_CNT_W-1:0]  C_PERIOD_LAST = C_CNT_W'(PERIOD_CNT);
  localparam logic [C_STEP_W-1:0] C_STEP_LAST   = C_STEP_W'(STEP_PERIODS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [C_CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic                tick_q, tick_d;
  logic [C_STEP_W-1:0] step_cnt_q, step_cnt_d;
  state_t              state_q, state_d;
  logic [WL-1:0]       duty_q, duty_d;
  logic [WL-1:0]       target_q, target_d;
  logic [WL-1:0]       step_q, step_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef PWM_FADE_BREATHE_EN
  // breathe_q: breathe mode active; to_zero_q: current leg heads for 0.
  logic                breathe_q, breathe_d;
  logic                to_zero_q, to_zero_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic          w_step_event;
  logic [WL-1:0] w_goal;
  logic [WL-1:0] w_start_step;
  logic          w_up;
  logic [WL-1:0] w_gap;
  logic [WL-1:0] w_next_duty;

  // Free-running period counter and its registered end-of-period tick. The
  // tick is computed from the next count so it lines up with the cycle in
  // which the counter actually holds PERIOD_CNT.
  always_comb begin
    period_cnt_d = (period_cnt_q == C_PERIOD_LAST) ? '0
                                                   : period_cnt_q + C_CNT_W'(1);
    tick_d       = (period_cnt_d == C_PERIOD_LAST);
  end

  // Step counter advances once per period; it is never cleared by i_start,
  // so step events stay on a fixed grid relative to reset.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (tick_q) begin
      step_cnt_d = (step_cnt_q == C_STEP_LAST) ? '0 : step_cnt_q + C_STEP_W'(1);
    end
  end

  assign w_step_event = tick_q && (step_cnt_q == C_STEP_LAST);

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign w_start_step = (bus.i_step == '0) ? WL'(1) : bus.i_step;

`ifdef PWM_FADE_BREATHE_EN
  assign w_goal = to_zero_q ? '0 : target_q;
`else
  assign w_goal = target_q;

  logic w_unused_breathe;
  assign w_unused_breathe = bus.i_breathe;
`endif

  // Move toward the goal by step_q, saturating at the goal. Working on the
  // unsigned gap keeps the arithmetic inside WL bits: no wrap past 0 or
  // 2^WL-1 can occur because the add/subtract only happens when the gap
  // exceeds the step.
  always_comb begin
    w_up        = (duty_q < w_goal);
    w_gap       = w_up ? (w_goal - duty_q) : (duty_q - w_goal);
    w_next_duty = w_goal;
    if (w_gap > step_q) begin
      w_next_duty = w_up ? (duty_q + step_q) : (duty_q - step_q);
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    done_d   = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
    breathe_d = breathe_q;
    to_zero_d = to_zero_q;
`endif

    if (bus.i_stop) begin
      // Stop outranks a simultaneous start; the duty is simply held.
      state_d = IDLE;
`ifdef PWM_FADE_BREATHE_EN
      breathe_d = 1'b0;
      to_zero_d = 1'b0;
`endif
    end else if (bus.i_start) begin
      // Valid in both states. A start coinciding with a step event takes
      // precedence and that event is skipped; direction is re-derived from
      // the current duty at the next step event.
      target_d = bus.i_target;
      step_d   = w_start_step;
`ifdef PWM_FADE_BREATHE_EN
      breathe_d = bus.i_breathe;
      to_zero_d = 1'b0;
`endif
      if (bus.i_target == duty_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
        breathe_d = 1'b0;
`endif
      end else begin
        state_d = RAMP;
      end
    end else if ((state_q == RAMP) && w_step_event) begin
      duty_d = w_next_duty;
      if (w_next_duty == w_goal) begin
        done_d = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
        if (breathe_q) begin
          to_zero_d = ~to_zero_q;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
    end

    // Registered busy flag tracks the state being entered, so it rises the
    // cycle after i_start and falls on the same edge as o_done.
    busy_d = (state_d == RAMP);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q <= '0;
      tick_q       <= 1'b0;
      step_cnt_q   <= '0;
      state_q      <= IDLE;
      duty_q       <= '0;
      target_q     <= '0;
      step_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      tick_q       <= tick_d;
      step_cnt_q   <= step_cnt_d;
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef PWM_FADE_BREATHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breathe_q <= 1'b0;
      to_zero_q <= 1'b0;
    end else begin
      breathe_q <= breathe_d;
      to_zero_q <= to_zero_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // --------------------------------------------------------------------------
  assign bus.o_duty_cycle  = duty_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_period_tick = tick_q;

endmodule
`default_nettype wire
